// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of free preg IDs with a shadow
// bitmap that rejects double frees and releases of p0.
module preg_free_list #(
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    localparam int DEPTH = NUM_PREG - NUM_AREG,
    localparam int IW = $clog2(NUM_PREG),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [IW-1:0] alloc_preg,
    output logic          stall,
    input  logic          rel0_valid,
    input  logic [IW-1:0] rel0_preg,
    input  logic          rel1_valid,
    input  logic [IW-1:0] rel1_preg,
    output logic [CW-1:0] free_count,
    output logic          err_free
);

    // Allocation handshake: alloc_valid acts as ready; a pop happens on any
    // cycle where alloc_req && alloc_valid, and alloc_preg is the popped ID.
    logic [IW-1:0]    mem_q [DEPTH];
    logic [IW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NUM_PREG-1:0] free_map_q, free_map_d;
    logic             err_q, err_d;

    logic             pop;
    logic [IW-1:0]    popped_id;
    logic             busy0, busy1;
    logic             acc0, acc1;
    logic             drop0, drop1;
    logic [CW:0]      occ0, occ1;
    logic [PW-1:0]    wr1_idx;

    assign alloc_valid = (count_q != '0);
    assign alloc_preg  = mem_q[head_q];
    assign stall       = alloc_req && (count_q == '0);
    assign free_count  = count_q;
    assign err_free    = err_q;

    always_comb begin
        pop       = alloc_req && (count_q != '0);
        popped_id = mem_q[head_q];

        // An ID leaving the list this cycle counts as allocated already.
        busy0 = free_map_q[rel0_preg] && !(pop && popped_id == rel0_preg);
        busy1 = free_map_q[rel1_preg] && !(pop && popped_id == rel1_preg);

        occ0  = {1'b0, count_q} - (CW+1)'(pop);
        acc0  = rel0_valid && (rel0_preg != '0) && !busy0 && (occ0 < (CW+1)'(DEPTH));
        drop0 = rel0_valid && (rel0_preg != '0) && !acc0;

        occ1  = occ0 + (CW+1)'(acc0);
        acc1  = rel1_valid && (rel1_preg != '0) && !busy1
                && !(acc0 && rel1_preg == rel0_preg)
                && (occ1 < (CW+1)'(DEPTH));
        drop1 = rel1_valid && (rel1_preg != '0) && !acc1;

        wr1_idx = tail_q + PW'(acc0);

        mem_d      = mem_q;
        free_map_d = free_map_q;
        head_d     = head_q + PW'(pop);
        tail_d     = tail_q + PW'(acc0) + PW'(acc1);
        count_d    = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
        err_d      = err_q || drop0 || drop1;

        if (pop) begin
            free_map_d[popped_id] = 1'b0;
        end
        if (acc0) begin
            mem_d[tail_q]         = rel0_preg;
            free_map_d[rel0_preg] = 1'b1;
        end
        if (acc1) begin
            mem_d[wr1_idx]        = rel1_preg;
            free_map_d[rel1_preg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= IW'(NUM_AREG + i);
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CW'(DEPTH);
            free_map_q <= {{DEPTH{1'b1}}, {NUM_AREG{1'b0}}};
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            free_map_q <= free_map_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Scoreboard bench for preg_free_list: directed stimulus pushes expected
// {stall, alloc_preg} entries; a negedge monitor pops and compares them.
module tb_preg_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       stall;
    logic       rel0_valid;
    logic [5:0] rel0_preg;
    logic       rel1_valid;
    logic [5:0] rel1_preg;
    logic [5:0] free_count;
    logic       err_free;

    int n_checks = 0;
    int n_pass   = 0;

    // Entry layout: bit 6 = expected stall, bits 5:0 = expected alloc_preg.
    logic [6:0] exp_q[$];

    preg_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_valid(alloc_valid),
        .alloc_preg (alloc_preg),
        .stall      (stall),
        .rel0_valid (rel0_valid),
        .rel0_preg  (rel0_preg),
        .rel1_valid (rel1_valid),
        .rel1_preg  (rel1_preg),
        .free_count (free_count),
        .err_free   (err_free)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic req, input logic v0, input logic [5:0] p0,
                        input logic v1, input logic [5:0] p1);
        alloc_req  = req;
        rel0_valid = v0;
        rel0_preg  = p0;
        rel1_valid = v1;
        rel1_preg  = p1;
        @(posedge clk);
        #1;
        alloc_req  = 1'b0;
        rel0_valid = 1'b0;
        rel0_preg  = '0;
        rel1_valid = 1'b0;
        rel1_preg  = '0;
    endtask

    task automatic pop_expect(input logic [5:0] id);
        exp_q.push_back({1'b0, id});
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_alloc_valid"}, int'(alloc_valid), 1);
        check({tag, "_alloc_preg"},  int'(alloc_preg), 32);
        check({tag, "_free_count"},  int'(free_count), 32);
        check({tag, "_stall"},       int'(stall), 0);
        check({tag, "_err_free"},    int'(err_free), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (alloc_req) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_req", 1, 0);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                check("mon_stall", int'(stall), int'(e[6]));
                check("mon_alloc_valid", int'(alloc_valid), int'(!e[6]));
                if (!e[6]) begin
                    check("mon_alloc_preg", int'(alloc_preg), int'(e[5:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        alloc_req  = 1'b0;
        rel0_valid = 1'b0;
        rel0_preg  = '0;
        rel1_valid = 1'b0;
        rel1_preg  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("reset");

        // Drain the whole list, then one stalled request.
        for (int i = 0; i < 32; i++) pop_expect(6'(32 + i));
        check("drain_free_count", int'(free_count), 0);
        check("drain_alloc_valid", int'(alloc_valid), 0);
        exp_q.push_back(7'h40);
        step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);

        // Release two while empty: still stalls this cycle, no bypass.
        exp_q.push_back(7'h40);
        step(1'b1, 1'b1, 6'd5, 1'b1, 6'd40);
        check("refill_free_count", int'(free_count), 2);
        check("refill_alloc_preg", int'(alloc_preg), 5);
        pop_expect(6'd5);
        pop_expect(6'd40);
        check("refill_drained", int'(free_count), 0);
        check("refill_no_err", int'(err_free), 0);

        // Double free of an ID already in the list.
        do_reset();
        step(1'b0, 1'b1, 6'd33, 1'b0, 6'd0);
        check("dup_err_free", int'(err_free), 1);
        check("dup_free_count", int'(free_count), 32);

        // Release of p0 is ignored without error.
        do_reset();
        step(1'b0, 1'b1, 6'd0, 1'b0, 6'd0);
        check("p0_err_free", int'(err_free), 0);
        check("p0_free_count", int'(free_count), 32);

        // Full list: pop plus release fits; release alone overflows.
        exp_q.push_back({1'b0, 6'd32});
        step(1'b1, 1'b1, 6'd5, 1'b0, 6'd0);
        check("full_poprel_count", int'(free_count), 32);
        check("full_poprel_err", int'(err_free), 0);
        step(1'b0, 1'b1, 6'd6, 1'b0, 6'd0);
        check("overflow_err", int'(err_free), 1);
        check("overflow_count", int'(free_count), 32);

        // Same ID in both slots: only slot 0 is taken.
        do_reset();
        for (int i = 0; i < 32; i++) pop_expect(6'(32 + i));
        step(1'b0, 1'b1, 6'd7, 1'b1, 6'd7);
        check("pair_free_count", int'(free_count), 1);
        check("pair_err_free", int'(err_free), 1);
        pop_expect(6'd7);
        check("pair_drained", int'(free_count), 0);

        // Wrap-around: pop 20, release 1..20 in pairs, pop 20 more.
        do_reset();
        for (int i = 0; i < 20; i++) pop_expect(6'(32 + i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 6'(2*i + 1), 1'b1, 6'(2*i + 2));
        check("wrap_full_count", int'(free_count), 32);
        check("wrap_no_err", int'(err_free), 0);
        for (int i = 0; i < 12; i++) pop_expect(6'(52 + i));
        for (int i = 0; i < 8; i++) pop_expect(6'(1 + i));
        check("wrap_free_count", int'(free_count), 12);
        check("wrap_head_preg", int'(alloc_preg), 9);

        // Reset mid-stream discards the in-flight release.
        rst = 1'b1;
        step(1'b0, 1'b1, 6'd40, 1'b0, 6'd0);
        rst = 1'b0;
        check_reset_state("midrst");
        pop_expect(6'd32);
        check("midrst_after_pop", int'(free_count), 31);

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free list for the out-of-order core. The rename stage pops one free physical register per cycle for each destination register. The retire stage pushes back up to two superseded physical registers per cycle: the old mapping of each committing instruction's destination. The list is a circular FIFO of physical-register IDs. A free bitmap shadows it to reject double frees and releases of p0.

## Interface
- NUM_PREG, 64, total physical registers; IDs 0..63, ID width 6.
- NUM_AREG, 32, architectural registers; p0..p31 are the reset mappings, never in the list at reset.
- DEPTH, NUM_PREG-NUM_AREG = 32, FIFO capacity; pointer width 5, count width 6.

- clk  in  1  rising-edge clock; one clock, reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  rename needs a destination physical register this cycle.
- alloc_valid  out  1  list non-empty; alloc_preg is meaningful.
- alloc_preg  out  6  physical register at the FIFO head.
- stall  out  1  alloc_req && !alloc_valid.
- rel0_valid  in  1  retire slot 0 releases a register.
- rel0_preg  in  6  register released by slot 0 (older instruction).
- rel1_valid  in  1  retire slot 1 releases a register.
- rel1_preg  in  6  register released by slot 1 (younger instruction).
- free_count  out  6  number of entries in the list, 0..32.
- err_free  out  1  sticky: a release was dropped (double free or overflow).

## Operation
- State: mem[0..31] of 6-bit IDs, head (5 b), tail (5 b), count (6 b), free_map[63:0], err_free.
- Reset:
  - mem[i] = 32+i, head = 0, tail = 0, count = 32.
  - free_map bits 32..63 = 1, bits 0..31 = 0.
  - err_free = 0.
  - Resulting outputs: alloc_valid = 1, alloc_preg = 32, free_count = 32, stall = 0.
- Pop: fires when alloc_req && count != 0.
  - head <= head+1 (wraps 31 -> 0).
  - free_map[mem[head]] <= 0.
  - A request with count == 0 pops nothing; stall = 1 that cycle.
- Release acceptance, evaluated slot 0 first, then slot 1:
  - Ignored silently if preg == 0. x0 is never renamed, so this is not an error.
  - Dropped, err_free <= 1, if free_map[preg] == 1 (already free).
  - Dropped, err_free <= 1, if rel1_preg == rel0_preg and slot 0 was accepted.
  - Dropped, err_free <= 1, if no space. Space = count − pop + accepted_so_far < DEPTH.
  - Accepted: written at tail (slot 0) or tail+1 (slot 1 when slot 0 also accepted; else at tail); free_map[preg] <= 1.
  - tail advances by the number accepted, mod 32.
- count <= count + accepted − pop. Result is always within 0..32.
- The double-free check uses the registered free_map. A register popped this cycle and released this same cycle is treated as not free, so the release is accepted.
- err_free is cleared only by rst.

## Timing
- alloc_valid, alloc_preg, free_count: combinational from registered state only. No input-to-output path.
- stall: combinational from alloc_req and count.
- Pop latency: the popped ID is presented in the same cycle as alloc_req. The next ID appears after the edge.
- Release latency:
  - A released ID is first visible for allocation the cycle after acceptance.
  - No same-cycle bypass: at count == 0 with a release, the cycle still stalls.
- Full list (count == 32):
  - Pop plus release in the same cycle is legal.
  - The write at tail == head lands at the edge, after the head read.
- Wrap-around: pointers wrap freely. Full vs. empty is distinguished by count only.
- rst asserted mid-operation restores the full reset state at the next edge. In-flight requests and releases in that cycle are discarded.

## Test plan
- Reset, then idle -> alloc_valid = 1, alloc_preg = 32, free_count = 32, stall = 0, err_free = 0.
- alloc_req high 33 cycles, no releases:
  - Cycles 1–32 return 32..63.
  - free_count falls to 0.
  - Cycle 33 gives stall = 1, alloc_valid = 0.
- From empty, rel0 = 5 and rel1 = 40 with alloc_req high:
  - Same cycle: stall = 1.
  - Next cycle: alloc_preg = 5, free_count = 2.
  - Following pop: alloc_preg = 40.
- From reset, rel0 = 33 (already free) -> dropped, err_free = 1, free_count stays 32.
  - rel0 = 0 -> ignored, no error.
- Pop 32; release 7 and 7 in one cycle -> only one accepted, free_count = 1, err_free = 1.
- Wrap and reset:
  - Pop 20, release 20 (IDs 1..20), pop 20 more -> returns 52..63 then 1..8; pointers have wrapped.
  - Assert rst mid-stream -> state matches the reset check next cycle.
